// File: rtl/q_frag_pipe_pkg.sv
// q_frag_pipe_pkg: constants shared by the logic-primitive models.
//   Mode strings selecting the Q_FRAG behaviour, legal pipeline depth bounds,
//   and the fill-counter width that covers the largest depth.
package q_frag_pipe_pkg;

  localparam string ModeFlop = "FLOP";
  localparam string ModePipe = "PIPE";
  localparam string ModeTff  = "TFF";

  localparam int unsigned DepthMin = 1;
  localparam int unsigned DepthMax = 4;

  // Wide enough to hold 0..DepthMax.
  localparam int unsigned FillW = 3;

endpackage

// File: rtl/q_frag_bit.sv
// q_frag_bit: one Q_FRAG state bit.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active-high, loads Init (highest priority)
//   set_i : synchronous set, active-high, loads 1
//   en_i  : clock enable, loads d_i
//   d_i   : next-state data
//   q_o   : registered state
module q_frag_bit #(
  parameter logic Init = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  // Declaration value gives the pre-reset state in simulation.
  logic q_q = Init;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (set_i) begin
      q_d = 1'b1;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= Init;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/q_frag_pipe.sv
// q_frag_pipe: Q_FRAG register slice in FLOP, PIPE or TFF flavour.
//   QCK : clock, rising edge
//   QRT : synchronous reset, active-high (beats QST)
//   QST : synchronous set, active-high (beats QEN)
//   QEN : clock enable
//   QDI : direct data from routing
//   QDS : data select, 1 = QDI, 0 = CZ
//   CZ  : combinational output of the upstream C_FRAG
//   QZ  : last stage of the register/pipeline
//   QZV : QZ holds data captured since the last reset or set
(* MODES = "FLOP;PIPE;TFF" *)
module q_frag_pipe
  import q_frag_pipe_pkg::*;
#(
  parameter string       MODE  = "FLOP",
  parameter int unsigned DEPTH = 2,
  parameter logic        INIT  = 1'b0
) (
  input  logic QCK,
  input  logic QRT,
  input  logic QST,
  input  logic QEN,
  input  logic QDI,
  input  logic QDS,
  input  logic CZ,
  output logic QZ,
  output logic QZV
);

  localparam bit IsPipe  = (MODE == ModePipe);
  localparam bit IsTff   = (MODE == ModeTff);
  localparam bit ModeOk  = (MODE == ModeFlop) || IsPipe || IsTff;
  localparam bit DepthOk = (DEPTH >= DepthMin) && (DEPTH <= DepthMax);

  // FLOP and TFF are a single stage; DEPTH only matters for PIPE.
  localparam int unsigned NStages = IsPipe ? DEPTH : 1;
  localparam logic [FillW-1:0] FillMax = FillW'(NStages);

  if (!ModeOk) begin : g_bad_mode
    $error("q_frag_pipe: illegal MODE %s", MODE);
  end
  if (!DepthOk) begin : g_bad_depth
    $error("q_frag_pipe: DEPTH %0d outside legal range", DEPTH);
  end

  logic                 d;
  logic [NStages-1:0]   stage_in;
  logic [NStages-1:0]   stage_val;
  logic [FillW-1:0]     fill_q = '0;
  logic [FillW-1:0]     fill_d;

  always_comb begin
    d        = QDS ? QDI : CZ;
    stage_in = stage_val;
    // TFF folds the toggle into the bit's data so q_frag_bit stays a plain D flop.
    stage_in[0] = IsTff ? (stage_val[0] ^ d) : d;
    for (int i = 1; i < int'(NStages); i++) begin
      stage_in[i] = stage_val[i-1];
    end
  end

  for (genvar g = 0; g < int'(NStages); g++) begin : g_stage
    q_frag_bit #(
      .Init(INIT)
    ) u_bit (
      .clk_i(QCK),
      .rst_i(QRT),
      .set_i(QST),
      .en_i (QEN),
      .d_i  (stage_in[g]),
      .q_o  (stage_val[g])
    );
  end

  // Set data is not captured data, so QST restarts the fill like a reset.
  always_comb begin
    fill_d = fill_q;
    if (QST) begin
      fill_d = '0;
    end else if (QEN && (fill_q != FillMax)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign QZ  = stage_val[NStages-1];
  assign QZV = (fill_q == FillMax);

endmodule

// File: tb/tb_q_frag_pipe.sv
// tb_q_frag_pipe: directed checks of q_frag_pipe in every mode.
// All instances share the input stimulus; each scenario starts with a reset
// and inspects the instance it targets.
module tb_q_frag_pipe;

  logic qck = 1'b0;
  logic qrt = 1'b0;
  logic qst = 1'b0;
  logic qen = 1'b0;
  logic qdi = 1'b0;
  logic qds = 1'b0;
  logic cz  = 1'b0;

  logic qz_p3, qzv_p3, qz_p2, qzv_p2, qz_p4, qzv_p4;
  logic qz_t, qzv_t, qz_f, qzv_f, qz_f1, qzv_f1;

  int checks   = 0;
  int failures = 0;

  always #5 qck = ~qck;

  q_frag_pipe #(.MODE("PIPE"), .DEPTH(3), .INIT(1'b0)) u_p3 (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_p3), .QZV(qzv_p3));
  q_frag_pipe #(.MODE("PIPE"), .DEPTH(2), .INIT(1'b0)) u_p2 (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_p2), .QZV(qzv_p2));
  q_frag_pipe #(.MODE("PIPE"), .DEPTH(4), .INIT(1'b0)) u_p4 (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_p4), .QZV(qzv_p4));
  q_frag_pipe #(.MODE("TFF"), .DEPTH(2), .INIT(1'b0)) u_t (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_t), .QZV(qzv_t));
  q_frag_pipe #(.MODE("FLOP"), .DEPTH(2), .INIT(1'b0)) u_f (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_f), .QZV(qzv_f));
  q_frag_pipe #(.MODE("FLOP"), .DEPTH(2), .INIT(1'b1)) u_f1 (
    .QCK(qck), .QRT(qrt), .QST(qst), .QEN(qen), .QDI(qdi), .QDS(qds), .CZ(cz),
    .QZ(qz_f1), .QZV(qzv_f1));

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge qck);
    #1;
  endtask

  task automatic do_reset();
    qrt = 1'b1; qst = 1'b0; qen = 1'b0;
    tick();
    qrt = 1'b0;
  endtask

  initial begin
    logic [5:0] stream;
    logic [3:0] en_pat;
    logic [3:0] exp_p2;
    logic [3:0] exp_t;

    // Reset state across all flavours, including INIT=1.
    #2;
    do_reset();
    check_bit("rst_p3_qz", qz_p3, 1'b0);
    check_bit("rst_p3_qzv", qzv_p3, 1'b0);
    check_bit("rst_f1_qz", qz_f1, 1'b1);
    check_bit("rst_f1_qzv", qzv_f1, 1'b0);
    check_bit("rst_t_qz", qz_t, 1'b0);

    // PIPE depth 3: CZ stream 1,0,1,1 then zeros; QZ echoes it from the 3rd edge.
    stream = 6'b001101; // bit k = value on edge k+1: 1,0,1,1,0,0
    qds = 1'b0; qen = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cz = stream[k];
      tick();
      check_bit($sformatf("p3_qz_e%0d", k + 1), qz_p3, (k >= 2) ? stream[k-2] : 1'b0);
      check_bit($sformatf("p3_qzv_e%0d", k + 1), qzv_p3, (k >= 2));
    end

    // PIPE depth 2 with QEN 1,0,0,1: disabled edges add no latency.
    do_reset();
    qds = 1'b1; qdi = 1'b1; cz = 1'b0;
    en_pat = 4'b1001;
    exp_p2 = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      qen = en_pat[k];
      tick();
      check_bit($sformatf("p2_qz_e%0d", k + 1), qz_p2, exp_p2[k]);
      check_bit($sformatf("p2_qzv_e%0d", k + 1), qzv_p2, exp_p2[k]);
    end

    // TFF: QDI=1 toggles 1,0,1,0, then QDI=0 holds.
    do_reset();
    qds = 1'b1; qdi = 1'b1; qen = 1'b1;
    exp_t = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bit($sformatf("t_qz_e%0d", k + 1), qz_t, exp_t[k]);
    end
    check_bit("t_qzv", qzv_t, 1'b1);
    qdi = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_bit($sformatf("t_hold_e%0d", k + 1), qz_t, 1'b0);
    end

    // QRT with QST: reset wins. Load ones first so the reset is visible.
    qdi = 1'b1; qds = 1'b1; qen = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_bit("pre_rs_p4_qz", qz_p4, 1'b1);
    qrt = 1'b1; qst = 1'b1;
    tick();
    qrt = 1'b0; qst = 1'b0; qen = 1'b0;
    check_bit("rs_p4_qz", qz_p4, 1'b0);
    check_bit("rs_p4_qzv", qzv_p4, 1'b0);
    check_bit("rs_f_qz", qz_f, 1'b0);
    check_bit("rs_f1_qz", qz_f1, 1'b1);
    check_bit("rs_t_qzv", qzv_t, 1'b0);

    // QST alone with QEN=0: every stage 1, not valid.
    qst = 1'b1;
    tick();
    qst = 1'b0;
    check_bit("set_p3_qz", qz_p3, 1'b1);
    check_bit("set_p3_qzv", qzv_p3, 1'b0);
    check_bit("set_t_qz", qz_t, 1'b1);
    check_bit("set_f_qzv", qzv_f, 1'b0);

    // QST clears a full counter.
    qen = 1'b1; qdi = 1'b0;
    tick();
    check_bit("f_refill_qzv", qzv_f, 1'b1);
    qen = 1'b0; qst = 1'b1;
    tick();
    qst = 1'b0;
    check_bit("f_set_clr_qzv", qzv_f, 1'b0);

    // PIPE depth 4: reset after 2 enabled edges restarts the fill.
    do_reset();
    qds = 1'b1; qdi = 1'b1; qen = 1'b1;
    tick();
    tick();
    qrt = 1'b1;
    tick();
    qrt = 1'b0;
    check_bit("p4_abort_qzv", qzv_p4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bit($sformatf("p4_refill_qzv_e%0d", k + 1), qzv_p4, (k == 3));
    end
    check_bit("p4_refill_qz", qz_p4, 1'b1);

    // FLOP: CZ wiggles with QEN=0 leave QZ alone.
    do_reset();
    qds = 1'b0; qen = 1'b1; cz = 1'b1;
    tick();
    check_bit("f_load_qz", qz_f, 1'b1);
    qen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cz = ~cz;
      tick();
      check_bit($sformatf("f_hold_e%0d", k + 1), qz_f, 1'b1);
    end
    qen = 1'b1; cz = 1'b0;
    tick();
    check_bit("f_reload_qz", qz_f, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_frag_pipe.md
Q_FRAG_PIPE -- requirements
Module: q_frag_pipe

Interface
Parameters:
REQ-001 SHALL have parameter MODE, default "FLOP"; legal values "FLOP", "PIPE", "TFF".
REQ-002 SHALL have parameter DEPTH, default 2, range 1..4; used only in PIPE mode.
REQ-003 SHALL have parameter INIT, default 1'b0: value loaded into every state bit at reset.

Ports:
REQ-004 SHALL have port QCK, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port QRT, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port QST, input, 1 bit: synchronous set, active-high.
REQ-007 SHALL have port QEN, input, 1 bit: clock enable, active-high.
REQ-008 SHALL have port QDI, input, 1 bit: direct data from routing.
REQ-009 SHALL have port QDS, input, 1 bit: data select; 1 selects QDI, 0 selects CZ.
REQ-010 SHALL have port CZ, input, 1 bit: combinational output of the upstream C_FRAG.
REQ-011 SHALL have port QZ, output, 1 bit: registered result (last pipeline stage).
REQ-012 SHALL have port QZV, output, 1 bit: QZ holds data captured since the last reset/set.

Function
REQ-013 SHALL form the next-state input D as QDI when QDS=1, else CZ.
REQ-014 SHALL apply priority per QCK edge: QRT > QST > QEN > hold.
REQ-015 FLOP: with QEN=1, SHALL load D into the single stage; QZ follows one cycle after D is sampled.
REQ-016 PIPE: with QEN=1, SHALL shift D into stage 0 and stage i-1 into stage i; QZ = stage DEPTH-1; latency is DEPTH enabled edges.
REQ-017 PIPE: with QEN=0, SHALL hold all stages; disabled cycles add no latency and lose no data.
REQ-018 TFF: with QEN=1 and D=1, SHALL invert the state; with D=0, SHALL hold.
REQ-019 QST=1 (and QRT=0) SHALL set every stage to 1 regardless of QEN.
REQ-020 SHALL keep a fill counter, 0..DEPTH (DEPTH=1 for FLOP/TFF), that increments on each enabled edge and saturates at DEPTH.
REQ-021 QZV SHALL be 1 when fill counter = DEPTH, and 0 otherwise.
REQ-022 QST SHALL clear the fill counter to 0, because set data is not captured data.
REQ-023 When QRT and QST are both asserted, QRT SHALL win: stages = INIT, counter = 0.
REQ-024 Asserting QRT mid-fill SHALL abort the fill; the counter restarts from 0 on the next enabled edge.
REQ-025 CZ SHALL have no combinational path to QZ or QZV.
REQ-026 An illegal MODE or a DEPTH outside 1..4 SHALL be rejected at elaboration.

Reset
REQ-027 On a QCK edge with QRT=1, every stage SHALL = INIT, the counter SHALL = 0, and QZ SHALL = INIT and QZV = 0 from the next cycle on.
REQ-028 Before the first reset, state SHALL be INIT, for simulation only.
REQ-029 SHALL contain no asynchronous reset or set logic.

Structure
REQ-030 Mode string constants and the DEPTH bounds SHALL live in the shared logic-primitive include file used by the C_FRAG/T_FRAG/B_FRAG models.
REQ-031 One sub-module, q_frag_bit, SHALL implement a single state bit with sync reset/set/enable.
REQ-032 The pipeline SHALL instantiate q_frag_bit DEPTH times in a generate loop.
REQ-033 The fill counter and the MODE selection SHALL live in q_frag_pipe.
REQ-034 q_frag_pipe SHALL carry a MODES="FLOP;PIPE;TFF" attribute for architecture generation.

Verification
REQ-035 PIPE, DEPTH=3, INIT=0, QDS=0, QEN=1, CZ stream 1,0,1,1 after reset -> QZ shows 1,0,1,1 starting at the 3rd edge; QZV rises at the 3rd edge.
REQ-036 PIPE, DEPTH=2, QDS=1, QDI=1, QEN toggling 1,0,0,1 -> QZ=1 only after the 2nd enabled edge; QZV=1 at that same point.
REQ-037 TFF, QDS=1, QDI=1, QEN=1 for 4 edges from INIT=0 -> QZ = 1,0,1,0; then QDI=0 -> QZ holds.
REQ-038 Any mode, QRT=1 and QST=1 together -> QZ=INIT and QZV=0 next cycle; QST alone -> QZ=1 and QZV=0.
REQ-039 PIPE, DEPTH=4, QRT pulsed after 2 enabled edges -> QZV stays 0 until 4 further enabled edges.
REQ-040 FLOP, CZ toggled while QEN=0 -> QZ is unchanged.
